// File: rtl/rr_grant_ctrl_pkg.sv
// Shared types and defaults for the round-robin grant controller.
// Holds the FSM state encoding, the default width constants and a clog2 helper.
package rr_grant_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int DEF_N     = 8;
  localparam int DEF_IDX_W = clog2(DEF_N);

endpackage

// File: rtl/Arbiter8.sv
// Combinational lowest-set-bit arbiter used alongside the grant controller.
module Arbiter8 (
  input  logic [7:0] I,
  output logic [7:0] O
);

  assign O = I & ~(I - 8'd1);

endmodule

// File: rtl/rr_grant_ctrl_onehot_encode.sv
// Combinational one-hot to binary index encoder; a zero input encodes to 0.
module onehot_encode
  import rr_grant_ctrl_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic [N-1:0]     i_onehot,
  output logic [IDX_W-1:0] o_idx
);

  // OR of the indices of all set bits; exact for one-hot, 0 for no bits set.
  always_comb begin
    o_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (i_onehot[k]) begin
        o_idx = o_idx | IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: builds the masked request for an external
// lowest-set-bit arbiter and holds its registered one-hot result until release.
module rr_grant_ctrl
  import rr_grant_ctrl_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int IDX_W    = DEF_IDX_W,
  parameter int MAX_HOLD = 255,
  parameter int CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [N-1:0]     i_req,
  input  logic             i_done,
  output logic [N-1:0]     o_arb_i,
  input  logic [N-1:0]     i_arb_o,
  output logic [N-1:0]     o_gnt,
  output logic             o_gnt_valid,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  state_t           r_state;
  logic [N-1:0]     r_mask;
  logic [N-1:0]     r_gnt;
  logic             r_gnt_valid;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;

  logic [N-1:0]     w_masked_req;
  logic [N-1:0]     w_rel_mask;
  logic [IDX_W-1:0] w_arb_idx;
  logic             w_hold_expired;

  // Fall back to the full request vector when nobody above the last owner asks.
  assign w_masked_req = i_req & r_mask;
  assign o_arb_i      = (|w_masked_req) ? w_masked_req : i_req;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rel_mask
      assign w_rel_mask[gi] = (gi > int'(r_gnt_idx));
    end
  endgenerate

  assign w_hold_expired = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);

  onehot_encode #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_encode (
    .i_onehot (i_arb_o),
    .o_idx    (w_arb_idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_mask      <= '1;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|i_arb_o) begin
            r_gnt       <= i_arb_o;
            r_gnt_idx   <= w_arb_idx;
            r_gnt_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_done || w_hold_expired) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_idx   <= '0;
            r_mask      <= w_rel_mask;
            r_timeout   <= !i_done;
            r_state     <= ST_IDLE;
          end else if (r_cnt != HOLD_LIMIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_gnt_valid;
  assign o_gnt_idx   = r_gnt_idx;
  assign o_timeout   = r_timeout;

endmodule

// File: doc/rr_grant_ctrl.md
# rr_grant_ctrl

Round-robin grant controller that wraps the combinational lowest-set-bit arbiter (`Arbiter8`, O = I & ~(I−1)).
- Upstream: it builds the priority-masked request vector the arbiter consumes.
- Downstream: it registers the arbiter's one-hot result and holds it as a grant until the owner releases it, with a hold-timeout.
- It sits between N requesting clients and the shared resource they contend for.

## Interface

Parameters
- N, 8, number of requesters; must equal the arbiter width
- IDX_W, 3, width of the grant index; equals clog2(N)
- MAX_HOLD, 255, maximum number of cycles a grant is held without DONE; 0 disables the timeout
- CNT_W, 8, hold counter width; at least clog2(MAX_HOLD+1)

Ports
- CLK  in  1  single clock, rising edge
- RESET  in  1  synchronous, active-high reset
- REQ  in  N  level request per client
- DONE  in  1  the current owner releases the grant; ignored in IDLE
- ARB_I  out  N  masked request vector driven to the arbiter; combinational
- ARB_O  in  N  arbiter result; one-hot or zero, combinational from ARB_I
- GNT  out  N  registered one-hot grant
- GNT_VALID  out  1  a grant is held
- GNT_IDX  out  IDX_W  binary index of GNT
- TIMEOUT  out  1  one-cycle pulse on a forced release

## Operation

- State machine has two states: IDLE and HOLD.
- Priority mask register MASK[N]; bit k is set when k is strictly above the last granted index.
  - Reset value of MASK: all ones.
- ARB_I selection:
  - ARB_I = REQ & MASK when that value is nonzero.
  - Otherwise ARB_I = REQ.
  - ARB_I is driven in both states, but ARB_O is used only in IDLE.
- IDLE:
  - If ARB_O ≠ 0, capture GNT ← ARB_O and GNT_IDX ← encode(ARB_O), set GNT_VALID, clear the hold counter, and go to HOLD.
  - If ARB_O = 0, stay in IDLE.
- HOLD:
  - GNT, GNT_IDX and GNT_VALID are frozen.
  - Deasserting REQ[GNT_IDX] does not release the grant; only DONE or the timeout does.
  - The counter increments by 1 each HOLD cycle and saturates at MAX_HOLD.
- Release. Either of these causes a release at the next edge:
  - DONE = 1, or
  - MAX_HOLD ≠ 0 and the counter equals MAX_HOLD−1 with DONE = 0. This case also pulses TIMEOUT for exactly the cycle after that edge.
- Effect of a release:
  - GNT ← 0, GNT_VALID ← 0, GNT_IDX ← 0.
  - MASK ← bits (GNT_IDX+1 … N−1) set.
  - State goes to IDLE.
- Wrap-around: releasing index N−1 gives MASK = 0, so the full REQ vector is used and the lowest requester wins.
- If DONE and the timeout condition coincide, the release is treated as DONE and TIMEOUT stays 0.
- RESET mid-HOLD:
  - Next edge: IDLE, all outputs 0, MASK all ones, counter 0.
  - Any in-flight grant is dropped without TIMEOUT.
- Reset values: GNT = 0, GNT_VALID = 0, GNT_IDX = 0, TIMEOUT = 0. ARB_I = REQ while MASK is all ones.

## Timing

- Request-to-grant latency:
  - REQ stable before edge t in IDLE → GNT_VALID high after edge t.
  - That is 1 cycle, with a combinational path REQ→ARB_I→ARB_O→GNT register.
- Release:
  - DONE sampled high at edge t → GNT_VALID low after edge t.
  - The earliest next grant is after edge t+1, which guarantees one idle cycle between grants.
- Timeout: a grant issued at edge t with no DONE:
  - counter reaches MAX_HOLD−1 at edge t+MAX_HOLD−1;
  - forced release at edge t+MAX_HOLD;
  - TIMEOUT high for the cycle that follows that edge.
- DONE asserted in IDLE has no effect.
- GNT is always 0 or one-hot, and is never a non-subset of the REQ vector at the capture edge.

## Structure

- Shared package holds:
  - the state enum (IDLE, HOLD);
  - the default N/IDX_W constants;
  - a clog2 function.
- One sub-module, `onehot_encode`: N-bit one-hot to IDX_W binary, combinational, output 0 for a zero input.
- The arbiter is instantiated outside this block. The bench instantiates `Arbiter8` and ties ARB_I→I and O→ARB_O.

## Test plan

- Reset, then REQ = 8'b0010_1100 held, with DONE pulsed 1 cycle after each grant:
  - grants appear in order GNT = 0x04 (idx 2), 0x08 (idx 3), 0x20 (idx 5), then wrap to 0x04;
  - exactly one idle cycle separates consecutive grants.
- REQ = 0x81, DONE after each grant → grants alternate 0x01, 0x80, 0x01; the wrap from idx 7 uses MASK = 0.
- MAX_HOLD = 4, REQ = 0x10, DONE never asserted:
  - grant at edge t;
  - GNT_VALID falls and TIMEOUT pulses for one cycle after edge t+4;
  - regrant to 0x10 after edge t+5.
- DONE and the timeout condition in the same cycle → release with TIMEOUT = 0.
- REQ dropped to 0 during HOLD → GNT is held until DONE; afterwards the block stays IDLE with GNT_VALID = 0.
- RESET asserted mid-HOLD with GNT = 0x20 → next cycle all outputs are 0, and with REQ = 0x24 the next grant is 0x04, confirming MASK returned to all ones.
